multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the core's next datapath variant: one shared memory port for fetch and load/store, with IR, MDR and ALU-out registers.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the same datapath select/enable set as the single-cycle controller, plus PC/IR/MDR write enables and the memory request handshake.
- Sits between the datapath and the memory port.

Parameters:
- XLEN, 32, datapath width; no effect on control logic, carried for consistency.
- TRAP_HALT, 1, 1: an illegal opcode parks the FSM in TRAP; 0: it flags a one-cycle pulse and refetches.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  from IR (stable from DECODE onward).
- func3  in  3  from IR.
- func7  in  7  from IR.
- br_taken  in  1  branch comparator result, valid in EXEC.
- mem_ready  in  1  memory completes the request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  store qualifier, valid only with mem_req.
- addr_sel  out  1  0: memory address is PC; 1: memory address is ALU-out register.
- ir_we  out  1  latch IR.
- mdr_we  out  1  latch MDR.
- aluout_we  out  1  latch ALU-out register.
- pc_we  out  1  PC write.
- pc_sel  out  1  0: PC+4; 1: ALU-out (target).
- alu_sel  out  4  ALU op.
- rs1_pc_sel  out  1  1: ALU A is PC.
- rs2_imm_sel  out  1  1: ALU B is immediate.
- rf_en  out  1  register-file write.
- rd_data_sel  out  2  0: ALU-out; 1: MDR; 2: PC+4; 3: immediate (LUI).
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  illegal opcode detected.

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Only the state register is sequential. All outputs are combinational from state, opcode/func fields, mem_ready and br_taken.
- Reset:
  - state = RST asynchronously; all outputs 0 while in RST.
  - RST -> FETCH on the first clock edge after rst deasserts.
  - rst asserted in any state (including mid-MEM with mem_req high) drops all outputs to 0 immediately; no handshake completion is owed.
- FETCH:
  - mem_req=1, addr_sel=0.
  - If mem_ready: ir_we=1, next state DECODE; otherwise stay in FETCH.
- DECODE:
  - All enables 0.
  - Legal opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Legal -> EXEC; otherwise -> TRAP.
- EXEC:
  - alu_sel, rs1_pc_sel and rs2_imm_sel set per opcode; aluout_we=1.
  - OP / OP-IMM: alu_sel decoded from func3; func7[5] selects SUB/SRA. For OP-IMM, func7[5] is honoured only when func3 = 101.
  - LOAD, STORE, JALR: ADD, rs2_imm_sel=1.
  - AUIPC, JAL, BRANCH: ADD, rs1_pc_sel=1, rs2_imm_sel=1. BRANCH therefore computes PC+imm.
  - BRANCH: pc_we=1, pc_sel=br_taken, retire=1, next FETCH. Note that pc_sel=1 selects the ALU-out path; the datapath bypasses the ALU result to PC in this cycle.
  - LOAD / STORE -> MEM; all other opcodes -> WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - mem_ready with LOAD: mdr_we=1, next WB.
  - mem_ready with STORE: pc_we=1, pc_sel=0, retire=1, next FETCH.
  - Otherwise hold all MEM outputs and stay.
- WB:
  - rf_en=1, pc_we=1, retire=1, next FETCH.
  - rd_data_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_sel=1 for JAL/JALR, else 0.
- TRAP:
  - illegal=1, all enables 0.
  - TRAP_HALT=1: stay until reset.
  - TRAP_HALT=0: one cycle with pc_we=1, pc_sel=0, then FETCH.
- Latency, with zero memory wait:
  - BRANCH: 3 cycles.
  - OP / OP-IMM / LUI / AUIPC / JAL / JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- No output glitch obligations beyond combinational settling within the cycle.

Decomposition:
- Package xrv_pkg holds:
  - opcode constants: OPC_OP=0110011, OPC_OPIMM=0010011, OPC_LOAD, OPC_STORE, OPC_BRANCH=1100011, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC=0010111;
  - alu_op_e: 0 NONE, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, A AND;
  - rd_sel_e;
  - mc_state_e.
- Sub-module alu_dec: combinational opcode/func3/func7 -> alu_sel, shared with the single-cycle controller.

Test Plan:
- ADD (opcode 0110011, func3 0, func7 0), mem_ready=1 -> states FETCH, DECODE, EXEC, WB; alu_sel=1; rf_en=1 and rd_data_sel=0 in WB; retire at cycle 4.
- LW with mem_ready low 2 cycles in both FETCH and MEM -> mem_req held 3 cycles each; addr_sel 0 then 1; mdr_we only on the ready cycle; rd_data_sel=1; 9 cycles total.
- BEQ, br_taken=1 then br_taken=0 -> EXEC pc_we=1 with pc_sel=1 then 0; alu_sel=1, rs1_pc_sel=1; no rf_en; 3 cycles each.
- SW -> MEM: mem_we=1; then pc_we=1, pc_sel=0; rf_en never asserts.
- Opcode 0000000 with TRAP_HALT=1 -> TRAP, illegal=1, held 10 cycles, no mem_req. With TRAP_HALT=0 -> one pulse, then FETCH.
- rst asserted mid-MEM (mem_req=1) -> outputs 0 in the same cycle; after release: RST, then FETCH, mem_req=1 with addr_sel=0.

Source files
------------

// File: rtl/xrv_pkg.sv
// Shared encodings for the xrv control path: opcodes, ALU ops, write-back select and
// multi-cycle FSM states.
package xrv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_NONE = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_SLL  = 4'h3,
    ALU_SLT  = 4'h4,
    ALU_SLTU = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_SRA  = 4'h8,
    ALU_OR   = 4'h9,
    ALU_AND  = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    RD_ALU = 2'd0,
    RD_MDR = 2'd1,
    RD_PC4 = 2'd2,
    RD_IMM = 2'd3
  } rd_sel_e;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } mc_state_e;

  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU operation decode from opcode/func3/func7; shared between the
// single-cycle and multi-cycle controllers.
module alu_dec
  import xrv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output alu_op_e    alu_op_o
);

  logic alt;

  // Only func7[5] carries ALU meaning; the other bits are don't-care here.
  logic unused_func7;
  assign unused_func7 = ^{func7_i[6], func7_i[4:0]};

  always_comb begin
    alu_op_o = ALU_NONE;
    alt      = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_OPIMM: begin
        // Immediate forms reuse func7[5] only for SRAI; elsewhere it is immediate bits.
        alt = func7_i[5] && ((opcode_i == OPC_OP) || (func3_i == 3'b101));
        case (func3_i)
          3'b000:  alu_op_o = alt ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101:  alu_op_o = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR,
      OPC_AUIPC, OPC_JAL, OPC_BRANCH: alu_op_o = ALU_ADD;
      default:                        alu_op_o = ALU_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: one shared memory port, IR/MDR/ALU-out staging,
// every output decoded combinationally from the state register and IR fields.
//
// state  | meaning
// RST    | post-reset idle, all outputs low
// FETCH  | request instruction at PC, latch IR on mem_ready
// DECODE | legality check of opcode
// EXEC   | ALU operation into ALU-out; branches resolve and retire here
// MEM    | data access at ALU-out; stores retire here
// WB     | register-file write and PC update
// TRAP   | illegal opcode; halt or single-cycle skip depending on TRAP_HALT
module multicycle_ctrl
  import xrv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       aluout_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic [3:0] alu_sel,
  output logic       rs1_pc_sel,
  output logic       rs2_imm_sel,
  output logic       rf_en,
  output logic [1:0] rd_data_sel,
  output logic       retire,
  output logic       illegal
);

  mc_state_e state_q, state_d;
  alu_op_e   alu_op;
  logic      is_load, is_store, is_jump;

  // XLEN sizes nothing in the control path; this tie-off keeps the parameter referenced.
  logic [XLEN-1:0] unused_xlen;
  assign unused_xlen = '0;

  alu_dec u_alu_dec (
    .opcode_i (opcode),
    .func3_i  (func3),
    .func7_i  (func7),
    .alu_op_o (alu_op)
  );

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_jump  = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    aluout_we   = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    alu_sel     = ALU_NONE;
    rs1_pc_sel  = 1'b0;
    rs2_imm_sel = 1'b0;
    rf_en       = 1'b0;
    rd_data_sel = RD_ALU;
    retire      = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = opc_legal(opcode) ? S_EXEC : S_TRAP;

      S_EXEC: begin
        aluout_we = 1'b1;
        alu_sel   = alu_op;
        case (opcode)
          OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
            rs1_pc_sel  = 1'b1;
            rs2_imm_sel = 1'b1;
          end
          OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR: rs2_imm_sel = 1'b1;
          default: ;
        endcase
        // Taken branches steer the PC mux to the ALU result, bypassed by the datapath.
        if (opcode == OPC_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_en   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        pc_sel  = is_jump;
        state_d = S_FETCH;
        if (is_load)               rd_data_sel = RD_MDR;
        else if (is_jump)          rd_data_sel = RD_PC4;
        else if (opcode == OPC_LUI) rd_data_sel = RD_IMM;
      end

      S_TRAP: begin
        illegal = 1'b1;
        if (!TRAP_HALT) begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_RST;
    endcase
  end

endmodule
